// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO buffer.
// Pointer width function, configuration check and error-flag bundle.
package sync_fifo_pkg;

   typedef struct packed {
      logic ovf;
      logic unf;
   } err_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   // Depth must be a power of two; thresholds must satisfy ae < af <= depth.
   function automatic bit cfg_ok(input int depth, input int ae, input int af);
      return is_pow2(depth) && (ae < af) && (af <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// D_SIZE x F_DEPTH storage: synchronous write, asynchronous read, no reset.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i -> rdata_o.
module sync_fifo_ram #(
   parameter int D_SIZE  = 8,
   parameter int F_DEPTH = 8,
   localparam int A_W    = $clog2(F_DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [A_W-1:0]    waddr_i,
   input  logic [D_SIZE-1:0] wdata_i,
   input  logic [A_W-1:0]    raddr_i,
   output logic [D_SIZE-1:0] rdata_o
);

   logic [D_SIZE-1:0] mem_q [F_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with occupancy count, almost flags and sticky errors.
// Ports: w_clk, w_rstn (sync, active-low), w_data/w_inc write side,
//   r_inc/r_data/r_valid read side, full/empty/almost_full/almost_empty,
//   count, overflow/underflow (sticky), clr_err.
// Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read data.
module sync_fifo_buf
   import sync_fifo_pkg::*;
#(
   parameter int D_SIZE  = 8,
   parameter int F_DEPTH = 8,
   parameter int AF_THR  = F_DEPTH - 2,
   parameter int AE_THR  = 2,
   localparam int P_SIZE = ptr_w(F_DEPTH)
) (
   input  logic              w_clk,
   input  logic              w_rstn,
   input  logic [D_SIZE-1:0] w_data,
   input  logic              w_inc,
   input  logic              r_inc,
   output logic [D_SIZE-1:0] r_data,
   output logic              r_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [P_SIZE-1:0] count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int A_W = P_SIZE - 1;
   localparam bit CFG_OK = cfg_ok(F_DEPTH, AE_THR, AF_THR);
   localparam logic [P_SIZE-1:0] AF_V = P_SIZE'(AF_THR);
   localparam logic [P_SIZE-1:0] AE_V = P_SIZE'(AE_THR);

   generate
      if (!CFG_OK) begin : g_bad_cfg
         $error("sync_fifo_buf: invalid F_DEPTH or threshold setting");
      end
   endgenerate

   logic [P_SIZE-1:0] wptr_q, wptr_d;
   logic [P_SIZE-1:0] rptr_q, rptr_d;
   err_t              err_q, err_d;
   logic              wr_acc, rd_acc;
   logic [D_SIZE-1:0] rd_word;

   // Same index with opposite wrap bit means the writer lapped the reader.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[A_W] != rptr_q[A_W]) &&
                  (wptr_q[A_W-1:0] == rptr_q[A_W-1:0]);
   assign count = wptr_q - rptr_q;

   assign almost_full  = (count >= AF_V);
   assign almost_empty = (count <= AE_V);

   assign wr_acc = w_inc && !full;
   assign rd_acc = r_inc && !empty;

   assign overflow  = err_q.ovf;
   assign underflow = err_q.unf;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      err_d  = err_q;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (clr_err) err_d = '0;
      // A fresh error in the clearing cycle still sets its flag.
      if (w_inc && full)  err_d.ovf = 1'b1;
      if (r_inc && empty) err_d.unf = 1'b1;
   end

   always_ff @(posedge w_clk) begin
      if (!w_rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         err_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         err_q  <= err_d;
      end
   end

   sync_fifo_ram #(
      .D_SIZE  (D_SIZE),
      .F_DEPTH (F_DEPTH)
   ) u_ram (
      .clk_i   (w_clk),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[A_W-1:0]),
      .wdata_i (w_data),
      .raddr_i (rptr_q[A_W-1:0]),
      .rdata_o (rd_word)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown directly; r_inc acknowledges it.
   assign r_data  = rd_word;
   assign r_valid = !empty;
`else
   logic [D_SIZE-1:0] r_data_q, r_data_d;
   logic              r_valid_q, r_valid_d;

   always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = rd_acc;
      if (rd_acc) r_data_d = rd_word;
   end

   always_ff @(posedge w_clk) begin
      if (!w_rstn) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_data_q  <= r_data_d;
         r_valid_q <= r_valid_d;
      end
   end

   assign r_data  = r_data_q;
   assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Directed bench for sync_fifo_buf (D_SIZE=8, F_DEPTH=8).
// Vector table for fill/drain/error rows plus corner-case sequences.
module tb_sync_fifo_buf;

   logic       w_clk = 1'b0;
   logic       w_rstn;
   logic [7:0] w_data;
   logic       w_inc;
   logic       r_inc;
   logic [7:0] r_data;
   logic       r_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;
   logic       clr_err;

   int checks = 0;
   int errors = 0;

   always #5 w_clk = ~w_clk;

   sync_fifo_buf #(
      .D_SIZE  (8),
      .F_DEPTH (8)
   ) dut (
      .w_clk        (w_clk),
      .w_rstn       (w_rstn),
      .w_data       (w_data),
      .w_inc        (w_inc),
      .r_inc        (r_inc),
      .r_data       (r_data),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   typedef struct {
      logic       rstn;
      logic       wi;
      logic       ri;
      logic       clr;
      logic [7:0] wd;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       unf;
      logic       rv;
      logic [7:0] rd;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic rstn, input logic wi, input logic ri,
                       input logic clr, input logic [7:0] wd);
      w_rstn  = rstn;
      w_inc   = wi;
      r_inc   = ri;
      clr_err = clr;
      w_data  = wd;
      @(posedge w_clk);
      @(negedge w_clk);
   endtask

   function automatic vec_t mk(
      input logic rstn, input logic wi, input logic ri, input logic clr,
      input logic [7:0] wd, input logic [3:0] cnt, input logic ovf,
      input logic unf, input logic rv, input logic [7:0] rd);
      vec_t v;
      v.rstn = rstn; v.wi = wi; v.ri = ri; v.clr = clr; v.wd = wd;
      v.cnt = cnt;
      v.full = (cnt == 4'd8);
      v.empty = (cnt == 4'd0);
      v.af = (cnt >= 4'd6);
      v.ae = (cnt <= 4'd2);
      v.ovf = ovf; v.unf = unf; v.rv = rv; v.rd = rd;
      return v;
   endfunction

   initial begin
      logic [7:0] exp_rd;
      w_rstn = 1'b0; w_inc = 1'b0; r_inc = 1'b0;
      clr_err = 1'b0; w_data = 8'h00;
      @(negedge w_clk);

      // reset, then fill with 0x11..0x88
      vq.push_back(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 8'h00));
      for (int k = 1; k <= 8; k++)
         vq.push_back(mk(1, 1, 0, 0, 8'(8'h11 * k), 4'(k),
                         0, 0, 0, 8'h00));
      // full: write dropped, read of head accepted
      vq.push_back(mk(1, 1, 1, 0, 8'h99, 4'd7, 1, 0, 1, 8'h11));
      vq.push_back(mk(1, 0, 0, 1, 8'h00, 4'd7, 0, 0, 0, 8'h11));
      for (int j = 2; j <= 8; j++)
         vq.push_back(mk(1, 0, 1, 0, 8'h00, 4'(8 - j),
                         0, 0, 1, 8'(8'h11 * j)));
      // empty: read rejected, write accepted
      vq.push_back(mk(1, 1, 1, 0, 8'hA5, 4'd1, 0, 1, 0, 8'h88));
      vq.push_back(mk(1, 0, 1, 0, 8'h00, 4'd0, 0, 1, 1, 8'hA5));
      // clear and new underflow in one cycle: set wins
      vq.push_back(mk(1, 0, 1, 1, 8'h00, 4'd0, 0, 1, 0, 8'hA5));
      vq.push_back(mk(1, 0, 0, 1, 8'h00, 4'd0, 0, 0, 0, 8'hA5));

      foreach (vq[i]) begin
         step(vq[i].rstn, vq[i].wi, vq[i].ri, vq[i].clr, vq[i].wd);
         chk($sformatf("v%0d count", i), 32'(count), 32'(vq[i].cnt));
         chk($sformatf("v%0d full", i), 32'(full), 32'(vq[i].full));
         chk($sformatf("v%0d empty", i), 32'(empty), 32'(vq[i].empty));
         chk($sformatf("v%0d af", i), 32'(almost_full), 32'(vq[i].af));
         chk($sformatf("v%0d ae", i), 32'(almost_empty), 32'(vq[i].ae));
         chk($sformatf("v%0d ovf", i), 32'(overflow), 32'(vq[i].ovf));
         chk($sformatf("v%0d unf", i), 32'(underflow), 32'(vq[i].unf));
`ifndef SYNC_FIFO_FWFT_EN
         chk($sformatf("v%0d rvalid", i), 32'(r_valid), 32'(vq[i].rv));
         chk($sformatf("v%0d rdata", i), 32'(r_data), 32'(vq[i].rd));
`endif
      end

      // streaming: one word prefilled, 20 simultaneous read+write
      step(1, 1, 0, 0, 8'd100);
      chk("stream prefill count", 32'(count), 32'd1);
      for (int i = 1; i <= 20; i++) begin
         step(1, 1, 1, 0, 8'(100 + i));
         chk($sformatf("stream%0d count", i), 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
         exp_rd = 8'(100 + i);
`else
         exp_rd = 8'(99 + i);
`endif
         chk($sformatf("stream%0d rdata", i), 32'(r_data), 32'(exp_rd));
         chk($sformatf("stream%0d rvalid", i), 32'(r_valid), 32'd1);
      end
      step(1, 0, 1, 0, 8'h00);
      chk("stream drain empty", 32'(empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("stream drain rdata", 32'(r_data), 32'd120);
`endif

      // reset mid-operation with count=5 and an error flag set
      step(1, 0, 1, 0, 8'h00);
      chk("pre-rst unf", 32'(underflow), 32'd1);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 8'(8'h50 + i));
      step(1, 0, 1, 0, 8'h00);
      chk("pre-rst count", 32'(count), 32'd5);
      chk("pre-rst rvalid", 32'(r_valid), 32'd1);
      step(0, 1, 1, 0, 8'hEE);
      chk("rst count", 32'(count), 32'd0);
      chk("rst empty", 32'(empty), 32'd1);
      chk("rst full", 32'(full), 32'd0);
      chk("rst unf", 32'(underflow), 32'd0);
      chk("rst ovf", 32'(overflow), 32'd0);
      chk("rst af", 32'(almost_full), 32'd0);
      chk("rst ae", 32'(almost_empty), 32'd1);
      chk("rst rvalid", 32'(r_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rst rdata", 32'(r_data), 32'd0);
`endif
      step(1, 0, 1, 0, 8'h00);
      chk("post-rst dropped", 32'(underflow), 32'd1);
      step(1, 0, 0, 1, 8'h00);

      // read latency of a single word written into an empty FIFO
      step(1, 1, 0, 0, 8'h3C);
      chk("3c count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("3c fwft rvalid", 32'(r_valid), 32'd1);
      chk("3c fwft rdata", 32'(r_data), 32'h3C);
      step(1, 0, 1, 0, 8'h00);
      chk("3c fwft ack rvalid", 32'(r_valid), 32'd0);
`else
      chk("3c no-read rvalid", 32'(r_valid), 32'd0);
      step(1, 0, 1, 0, 8'h00);
      chk("3c rvalid", 32'(r_valid), 32'd1);
      chk("3c rdata", 32'(r_data), 32'h3C);
      step(1, 0, 0, 0, 8'h00);
      chk("3c pulse", 32'(r_valid), 32'd0);
`endif
      chk("3c empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
